// File: rtl/fifo_frame_reader_if.sv
// Bundles the FIFO read port and the framed output stream of fifo_frame_reader.
// The master modport is the reader; the slave modport is the FIFO plus the sink.
interface fifo_frame_reader_if #(
    parameter int unsigned p_nbit_d = 8
);
    logic                rd;
    logic [p_nbit_d-1:0] rdata;
    logic                rempty;
    logic                out_valid;
    logic                out_ready;
    logic [p_nbit_d-1:0] out_data;
    logic                out_sop;
    logic                out_eop;

    modport master (
        output rd,
        input  rdata,
        input  rempty,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sop,
        output out_eop
    );

    modport slave (
        input  rd,
        output rdata,
        output rempty,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sop,
        input  out_eop
    );
endinterface

// File: rtl/fifo_frame_reader.sv
// Reads p_frame_len samples from a latency-p_rd_lat FIFO and emits them as a frame:
// sync header (sop), payload, additive checksum (eop). A 4-entry skid buffer absorbs
// the FIFO read latency so the sink can apply backpressure without losing data.
module fifo_frame_reader #(
    parameter int unsigned         p_nbit_d    = 8,
    parameter int unsigned         p_frame_len = 16,
    parameter int unsigned         p_rd_lat    = 2,
    parameter logic [p_nbit_d-1:0] p_sync      = 8'hA5
) (
    input  logic                       rclk,
    input  logic                       rrst_n,
    input  logic                       en,
    fifo_frame_reader_if.master        bus,
    output logic                       busy,
    output logic [15:0]                frame_cnt
);

    localparam logic [7:0] FrameLen = 8'(p_frame_len);
    localparam logic [7:0] LastIdx  = 8'(p_frame_len - 1);

    typedef enum logic [1:0] {StIdle, StHdr, StPay, StCsum} state_e;

    state_e              state_q, state_d;
    logic [7:0]          req_cnt_q, req_cnt_d;
    logic [7:0]          pop_cnt_q, pop_cnt_d;
    logic [p_rd_lat-1:0] vld_q, vld_d;
    logic [p_nbit_d-1:0] mem_q [4];
    logic [p_nbit_d-1:0] mem_d [4];
    logic [1:0]          wr_ptr_q, wr_ptr_d;
    logic [1:0]          rd_ptr_q, rd_ptr_d;
    logic [2:0]          occ_q, occ_d;
    logic [p_nbit_d-1:0] csum_q, csum_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic [1:0]          inflight;
    logic                rd_ok;
    logic                enq;
    logic                pop;
    logic                xfer;
    logic                out_valid_c;
    logic [p_nbit_d-1:0] out_data_c;
    logic                out_sop_c;
    logic                out_eop_c;

    // Read strobe: only while framing, data available, frame not fully requested, and
    // room in the skid buffer for everything already on its way.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(p_rd_lat); i++) begin
            inflight = inflight + {1'b0, vld_q[i]};
        end
        rd_ok = ((state_q == StHdr) || (state_q == StPay)) && !bus.rempty &&
                (req_cnt_q < FrameLen) &&
                (({1'b0, occ_q} + {2'b00, inflight}) < 4'd4);
    end

    // Output word selection, derived from registered state only.
    always_comb begin
        out_valid_c = 1'b0;
        out_data_c  = '0;
        out_sop_c   = 1'b0;
        out_eop_c   = 1'b0;
        unique case (state_q)
            StHdr: begin
                out_valid_c = 1'b1;
                out_data_c  = p_sync;
                out_sop_c   = 1'b1;
            end
            StPay: begin
                out_valid_c = (occ_q != 3'd0);
                out_data_c  = mem_q[rd_ptr_q];
            end
            StCsum: begin
                out_valid_c = 1'b1;
                out_data_c  = csum_q;
                out_eop_c   = 1'b1;
            end
            default: ;
        endcase
    end

    assign enq  = vld_q[p_rd_lat-1];
    assign xfer = out_valid_c && bus.out_ready;
    assign pop  = (state_q == StPay) && xfer;

    // Outputs are forced quiet while reset is held.
    assign bus.rd        = rrst_n && rd_ok;
    assign bus.out_valid = rrst_n && out_valid_c;
    assign bus.out_data  = rrst_n ? out_data_c : '0;
    assign bus.out_sop   = rrst_n && out_sop_c;
    assign bus.out_eop   = rrst_n && out_eop_c;
    assign busy          = rrst_n && (state_q != StIdle);
    assign frame_cnt     = frame_cnt_q;

    // Next state for the FSM, skid buffer, in-flight tracker and checksum.
    always_comb begin
        state_d     = state_q;
        req_cnt_d   = req_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        csum_d      = csum_q;
        frame_cnt_d = frame_cnt_q;

        vld_d    = '0;
        vld_d[0] = rd_ok;
        for (int i = 1; i < int'(p_rd_lat); i++) begin
            vld_d[i] = vld_q[i-1];
        end

        if (rd_ok) begin
            req_cnt_d = req_cnt_q + 8'd1;
        end
        if (enq) begin
            mem_d[wr_ptr_q] = bus.rdata;
            wr_ptr_d        = wr_ptr_q + 2'd1;
            csum_d          = csum_q + bus.rdata;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 2'd1;
            pop_cnt_d = pop_cnt_q + 8'd1;
        end
        case ({enq, pop})
            2'b10:   occ_d = occ_q + 3'd1;
            2'b01:   occ_d = occ_q - 3'd1;
            default: occ_d = occ_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d   = StHdr;
                    req_cnt_d = '0;
                    pop_cnt_d = '0;
                    csum_d    = '0;
                end
            end
            StHdr: begin
                if (xfer) state_d = StPay;
            end
            StPay: begin
                if (pop && (pop_cnt_q == LastIdx)) state_d = StCsum;
            end
            StCsum: begin
                if (xfer) begin
                    state_d     = StIdle;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any partial frame.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q     <= StIdle;
            req_cnt_q   <= '0;
            pop_cnt_q   <= '0;
            vld_q       <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            csum_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            req_cnt_q   <= req_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            vld_q       <= vld_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            csum_q      <= csum_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // The rd gating must make overflow impossible; these catch a broken gate.
    a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
        !(enq && !pop && (occ_q == 3'd4)));
    a_occ_bound: assert property (@(posedge rclk) disable iff (!rrst_n) occ_q <= 3'd4);

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: a latency-2 FIFO model feeds the DUT, a frame-level model
// predicts header/payload/checksum words, and scenario tasks compare what the sink sees.
module tb_fifo_frame_reader;

    localparam int unsigned NB  = 8;
    localparam int unsigned FL  = 4;
    localparam int unsigned LAT = 2;

    logic        rclk = 1'b0;
    logic        rrst_n;
    logic        en;
    logic        busy;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    fifo_frame_reader_if #(.p_nbit_d(NB)) bus ();

    fifo_frame_reader #(
        .p_nbit_d   (NB),
        .p_frame_len(FL),
        .p_rd_lat   (LAT),
        .p_sync     (8'hA5)
    ) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .en       (en),
        .bus      (bus),
        .busy     (busy),
        .frame_cnt(frame_cnt)
    );

    always #5 rclk = ~rclk;

    // FIFO model: a read in cycle t presents its word on rdata in cycle t+2.
    logic [7:0] src_q[$];
    logic [7:0] pipe0 = 8'h00;
    logic [7:0] pipe1 = 8'h00;
    int         rd_total = 0;
    int         cyc = 0;

    assign bus.rdata = pipe1;

    always @(posedge rclk) begin
        logic [7:0] w;
        w = 8'h00;
        if (bus.rd === 1'b1) begin
            rd_total <= rd_total + 1;
            if (src_q.size() > 0) w = src_q.pop_front();
        end
        pipe0      <= w;
        pipe1      <= pipe0;
        bus.rempty <= (src_q.size() == 0);
        cyc        <= cyc + 1;
    end

    // Frame model: header, payload in order, then the payload sum mod 256. {sop,eop,data}.
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    int         obs_rd[$];
    int         obs_cyc[$];
    int         stab_err;
    int         occ_err;
    int         exp_fc;

    function automatic void model_frame(input logic [7:0] s[$]);
        int sum;
        sum = 0;
        exp_q.push_back({2'b10, 8'hA5});
        foreach (s[i]) begin
            exp_q.push_back({2'b00, s[i]});
            sum = sum + int'(s[i]);
        end
        exp_q.push_back({2'b01, 8'(sum % 256)});
    endfunction

    task automatic push_src(input logic [7:0] s[$]);
        foreach (s[i]) src_q.push_back(s[i]);
    endtask

    task automatic clear_obs();
        exp_q.delete();
        obs_q.delete();
        obs_rd.delete();
        obs_cyc.delete();
        stab_err = 0;
        occ_err  = 0;
    endtask

    task automatic pulse_en();
        @(negedge rclk);
        en            = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge rclk);
        en = 1'b0;
    endtask

    // Sink: samples at the falling edge, drives out_ready at pct% duty, records transfers,
    // tracks hold stability and the bound on words requested but not yet delivered.
    task automatic collect(input int n, input int pct, input int budget, output int got);
        logic       pv, pr, rdy;
        logic [9:0] pw, w;
        int         base, pops;
        logic       in_frame;
        got = 0; pv = 1'b0; pr = 1'b0; pw = '0; base = 0; pops = 0; in_frame = 1'b0;
        while (got < n && budget > 0) begin
            @(negedge rclk);
            w = {bus.out_sop, bus.out_eop, bus.out_data};
            if (pv && !pr && (!bus.out_valid || w != pw)) stab_err++;
            if (bus.out_valid && bus.out_sop && !pw[9]) begin
                in_frame = 1'b1;
                base     = rd_total;
                pops     = 0;
            end
            if (in_frame && (rd_total - base - pops > 4)) occ_err++;
            rdy           = (int'($urandom_range(99)) < pct);
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                obs_q.push_back(w);
                obs_rd.push_back(rd_total);
                obs_cyc.push_back(cyc);
                got++;
                if (!bus.out_sop && !bus.out_eop) pops++;
            end
            pv = bus.out_valid;
            pr = rdy;
            pw = bus.out_valid ? w : '0;
            budget--;
        end
        @(negedge rclk);
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst_n = 1'b0;
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;
        exp_fc = 0;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        en = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge rclk);
        checks += 7;
        if (bus.rd !== 1'b0) begin failures++; $display("FAIL reset_rd got %b want 0", bus.rd); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        if (bus.out_sop !== 1'b0) begin failures++; $display("FAIL reset_sop got %b want 0", bus.out_sop); end
        if (bus.out_eop !== 1'b0) begin failures++; $display("FAIL reset_eop got %b want 0", bus.out_eop); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_data got %h want 00", bus.out_data); end
        if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_fcnt got %0d want 0", frame_cnt); end
        en = 1'b0;
        bus.out_ready = 1'b0;
        rrst_n = 1'b1;
        exp_fc = 0;
        @(negedge rclk);
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got %b want 0", busy); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got %b want 0", bus.out_valid); end
    endtask

    // Fixed frame with a fixed payload, sink always ready.
    task automatic test_frame(input string name, input logic [7:0] s[$]);
        int got;
        clear_obs();
        model_frame(s);
        push_src(s);
        pulse_en();
        collect(6, 100, 100, got);
        exp_fc++;
        checks++;
        if (got !== 6) begin failures++; $display("FAIL %s_count got %0d want 6", name, got); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_word%0d got %h want %h", name, i, obs_q[i], exp_q[i]);
            end
        end
        checks += 2;
        if (frame_cnt !== 16'(exp_fc)) begin failures++; $display("FAIL %s_fcnt got %0d want %0d", name, frame_cnt, exp_fc); end
        if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy got %b want 0", name, busy); end
    endtask

    task automatic test_empty_fifo();
        logic [7:0] s[$];
        int got;
        clear_obs();
        for (int i = 0; i < 4; i++) s.push_back(8'($urandom));
        model_frame(s);
        pulse_en();
        collect(1, 100, 20, got);
        checks++;
        if (got !== 1) begin failures++; $display("FAIL empty_hdr got %0d want 1", got); end
        for (int i = 0; i < 5; i++) begin
            @(negedge rclk);
            checks += 3;
            if (bus.rd !== 1'b0) begin failures++; $display("FAIL empty_stall_rd got %b want 0", bus.rd); end
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL empty_stall_valid got %b want 0", bus.out_valid); end
            if (busy !== 1'b1) begin failures++; $display("FAIL empty_stall_busy got %b want 1", busy); end
        end
        push_src(s);
        collect(5, 100, 100, got);
        exp_fc++;
        checks++;
        if (got !== 5) begin failures++; $display("FAIL empty_count got %0d want 5", got); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL empty_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (frame_cnt !== 16'(exp_fc)) begin failures++; $display("FAIL empty_fcnt got %0d want %0d", frame_cnt, exp_fc); end
    endtask

    task automatic test_random_ready();
        logic [7:0] s[$];
        int got, rd0;
        for (int f = 0; f < 3; f++) begin
            clear_obs();
            s.delete();
            for (int i = 0; i < 4; i++) s.push_back(8'($urandom));
            model_frame(s);
            push_src(s);
            rd0 = rd_total;
            pulse_en();
            collect(6, 30, 400, got);
            repeat (3) @(negedge rclk);
            exp_fc++;
            checks += 5;
            if (got !== 6) begin failures++; $display("FAIL rand%0d_count got %0d want 6", f, got); end
            if (stab_err !== 0) begin failures++; $display("FAIL rand%0d_stable got %0d want 0", f, stab_err); end
            if (occ_err !== 0) begin failures++; $display("FAIL rand%0d_occupancy got %0d want 0", f, occ_err); end
            if (rd_total - rd0 !== 4) begin failures++; $display("FAIL rand%0d_rd_pulses got %0d want 4", f, rd_total - rd0); end
            if (frame_cnt !== 16'(exp_fc)) begin failures++; $display("FAIL rand%0d_fcnt got %0d want %0d", f, frame_cnt, exp_fc); end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand%0d_word%0d got %h want %h", f, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s[$];
        int got;
        clear_obs();
        for (int i = 0; i < 4; i++) s.push_back(8'($urandom));
        model_frame(s);
        push_src(s);
        pulse_en();
        collect(3, 100, 50, got);
        checks++;
        if (got !== 3) begin failures++; $display("FAIL rmid_pre_count got %0d want 3", got); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rmid_pre_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        rrst_n = 1'b0;
        @(negedge rclk);
        checks += 3;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got %b want 0", bus.out_valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got %b want 0", busy); end
        if (frame_cnt !== 16'd0) begin failures++; $display("FAIL rmid_fcnt got %0d want 0", frame_cnt); end
        src_q.delete();
        rrst_n = 1'b1;
        exp_fc = 0;
        s.delete();
        s.push_back(8'h10); s.push_back(8'h20); s.push_back(8'h30); s.push_back(8'h40);
        test_frame("rmid_new", s);
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$];
        int got;
        do_reset();
        clear_obs();
        for (int f = 0; f < 3; f++) begin
            s.delete();
            for (int i = 0; i < 4; i++) s.push_back(8'($urandom));
            model_frame(s);
            push_src(s);
        end
        @(negedge rclk);
        en = 1'b1;
        collect(18, 100, 200, got);
        en = 1'b0;
        exp_fc = 3;
        checks++;
        if (got !== 18) begin failures++; $display("FAIL b2b_count got %0d want 18", got); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (obs_rd[6*k+6] - obs_rd[6*k+5] !== 0) begin
                failures++;
                $display("FAIL b2b_gap_rd%0d got %0d want 0", k, obs_rd[6*k+6] - obs_rd[6*k+5]);
            end
            if (obs_cyc[6*k+6] - obs_cyc[6*k+5] !== 2) begin
                failures++;
                $display("FAIL b2b_gap_cyc%0d got %0d want 2", k, obs_cyc[6*k+6] - obs_cyc[6*k+5]);
            end
        end
        checks++;
        if (obs_rd[17] - obs_rd[0] !== 12) begin
            failures++;
            $display("FAIL b2b_rd_total got %0d want 12", obs_rd[17] - obs_rd[0]);
        end
        @(negedge rclk);
        checks += 2;
        if (frame_cnt !== 16'(exp_fc)) begin failures++; $display("FAIL b2b_fcnt got %0d want %0d", frame_cnt, exp_fc); end
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got %b want 0", busy); end
    endtask

    initial begin
        logic [7:0] s[$];
        rrst_n        = 1'b0;
        en            = 1'b0;
        bus.out_ready = 1'b0;
        exp_fc        = 0;
        test_reset();
        s.delete();
        s.push_back(8'h01); s.push_back(8'h02); s.push_back(8'h03); s.push_back(8'h04);
        test_frame("basic", s);
        s.delete();
        s.push_back(8'hFF); s.push_back(8'hFF); s.push_back(8'h02); s.push_back(8'h01);
        test_frame("wrap", s);
        test_empty_fifo();
        test_random_ready();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_frame_reader.md
FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 SHALL have parameter p_nbit_d, default 8: sample/word width.
REQ-002 SHALL have parameter p_frame_len, default 16: payload samples per frame, range 1..255.
REQ-003 SHALL have parameter p_rd_lat, default 2: cycles from FIFO rd to valid rdata, either 1 or 2.
REQ-004 SHALL have parameter p_sync, default 8'hA5: header word.
REQ-005 SHALL have port rclk, input, 1: the single clock.
REQ-006 SHALL have port rrst_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port en, input, 1: permits a new frame to start.
REQ-008 SHALL have port rd, output, 1: FIFO read strobe.
REQ-009 SHALL have port rdata, input, p_nbit_d: FIFO read data.
REQ-010 SHALL have port rempty, input, 1: FIFO empty flag.
REQ-011 SHALL have port out_valid, output, 1: output word valid.
REQ-012 SHALL have port out_ready, input, 1: sink accepts the word.
REQ-013 SHALL have port out_data, output, p_nbit_d: output word.
REQ-014 SHALL have port out_sop, output, 1: marks the header word.
REQ-015 SHALL have port out_eop, output, 1: marks the checksum word.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-017 SHALL have port frame_cnt, output, 16: count of completed frames.

Function
REQ-018 SHALL implement an FSM with states IDLE, HDR, PAY and CSUM; a transfer is out_valid & out_ready in the same cycle.
REQ-019 IDLE: SHALL go to HDR on the clock edge where en=1, otherwise stay in IDLE; out_valid=0.
REQ-020 HDR: SHALL drive out_valid=1, out_data=p_sync and out_sop=1; on transfer SHALL go to PAY.
REQ-021 PAY: out_valid SHALL equal "skid buffer not empty" and out_data SHALL be the buffer head; on transfer SHALL pop the head, and SHALL go to CSUM on the transfer of the p_frame_len-th sample.
REQ-022 CSUM: SHALL drive out_valid=1, out_data = the checksum register and out_eop=1; on transfer SHALL go to IDLE and increment frame_cnt (mod 2^16).
REQ-023 SHALL latch en only in IDLE; deasserting en mid-frame SHALL NOT abort the frame.
REQ-024 SHALL keep out_data, out_sop and out_eop stable while out_valid=1 and out_ready=0.
REQ-025 SHALL assert rd (combinational, single cycle per word) only when all of the following hold:
  - the state is HDR or PAY;
  - rempty=0;
  - requested samples < p_frame_len;
  - buffer occupancy + in-flight reads < 4.
REQ-026 SHALL implement the skid buffer as a 4-entry FIFO; each rd SHALL enqueue rdata exactly p_rd_lat cycles later, tracked by a p_rd_lat-deep valid shift register.
REQ-027 SHALL never overflow the skid buffer; an overflow is a design error that assertions SHALL flag.
REQ-028 SHALL issue exactly p_frame_len rd pulses per frame, with no prefetch across frame boundaries.
REQ-029 SHALL compute the checksum as the sum of all payload samples mod 2^p_nbit_d, accumulated on enqueue, cleared on entry to HDR, and excluding the header.
REQ-030 SHALL throttle rd as FIFO-side backpressure: rempty=1 SHALL stall rd while output words still drain from the buffer.
REQ-031 With out_ready held at 1 and rempty held at 0, SHALL reach a sustained throughput of 1 payload word per cycle.
REQ-032 Simultaneous enqueue and pop SHALL leave the buffer occupancy unchanged.
REQ-033 With p_frame_len=1, PAY SHALL carry exactly one word.

Reset
REQ-034 With rrst_n=0 at a rising rclk edge, the block SHALL enter IDLE with the following cleared:
  - state;
  - counters;
  - skid buffer;
  - in-flight valid shift register;
  - checksum;
  - frame_cnt.
REQ-035 During reset and after reset the outputs SHALL be rd=0, out_valid=0, out_sop=0, out_eop=0, busy=0, out_data=0.
REQ-036 A reset mid-frame SHALL discard in-flight and buffered samples, whose loss is accepted at system level; no partial frame SHALL be emitted.

Verification
REQ-037 Bench SHALL cover, with p_frame_len=4, p_rd_lat=2, FIFO preloaded with 01,02,03,04, out_ready=1 and en pulsed: output sequence A5(sop), 01, 02, 03, 04, 0A(eop), then frame_cnt=1 and busy=0.
REQ-038 Bench SHALL cover payload FF, FF, 02, 01: checksum 01, confirming the mod-256 wrap.
REQ-039 Bench SHALL cover an empty FIFO with en=1: header sent, then stall in PAY with rd=0; after writing 4 words, the frame completes with the correct checksum.
REQ-040 Bench SHALL cover random out_ready at 30% duty: data order and stability hold, occupancy never exceeds 4, and exactly 4 rd pulses occur per frame.
REQ-041 Bench SHALL cover rrst_n=0 asserted after the 2nd payload transfer: the next cycle shows out_valid=0 and busy=0; the next frame starts with A5 and its checksum covers only new samples.
REQ-042 Bench SHALL cover en held at 1 across 3 back-to-back frames: frame_cnt=3, no rd between the CSUM transfer and HDR entry, and the header follows in the cycle after IDLE.
